// File: rtl/mini_alu_gen2_if.sv
// Bus bundle for mini_alu_gen2: instruction fetch port plus IP, LED and halt status.
// The master side is the program memory and observer. The slave side is the core.
interface mini_alu_gen2_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int IP_WIDTH   = 16,
   parameter int LED_WIDTH  = 8
);
   logic [4+3*ADDR_WIDTH-1:0] iInstruction;
   logic [IP_WIDTH-1:0]       oIP;
   logic [LED_WIDTH-1:0]      oLed;
   logic                      oHalted;

   modport master (output iInstruction, input oIP, oLed, oHalted);
   modport slave  (input iInstruction, output oIP, oLed, oHalted);
endinterface

// File: rtl/mini_alu_gen2.sv
// Multi-cycle mini ALU core: FETCH/EXEC control, a register file, and a
// shift-add multiplier that spends DATA_WIDTH cycles in the MUL state.
module mini_alu_gen2 #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int IP_WIDTH   = 16,
   parameter int LED_WIDTH  = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   mini_alu_gen2_if.slave   bus
);
   localparam int IW    = 4 + 3*ADDR_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = $clog2(DATA_WIDTH + 1);

   localparam logic [3:0] OP_LED  = 4'd1;
   localparam logic [3:0] OP_BLE  = 4'd2;
   localparam logic [3:0] OP_STO  = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_JMP  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_MUL  = 4'd7;
   localparam logic [3:0] OP_HALT = 4'd8;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MUL, S_HALT} state_t;

   state_t                r_state, w_next_state;
   logic [IW-1:0]         r_ir;
   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [IP_WIDTH-1:0]   r_ip;
   logic [LED_WIDTH-1:0]  r_led;
   logic [DATA_WIDTH-1:0] r_mcand, r_mplier, r_acc;
   logic [CW-1:0]         r_mcnt;

   logic [3:0]            w_op;
   logic [ADDR_WIDTH-1:0] w_dest, w_src1, w_src0;
   logic [DATA_WIDTH-1:0] w_a, w_b, w_acc_next, w_wdata;
   logic                  w_we, w_led_we, w_branch, w_ip_adv, w_mul_start, w_mul_last;

   assign w_op   = r_ir[IW-1 -: 4];
   assign w_dest = r_ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign w_src1 = r_ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign w_src0 = r_ir[ADDR_WIDTH-1:0];
   assign w_a    = r_regs[w_src1];
   assign w_b    = r_regs[w_src0];

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last = (r_state == S_MUL) && (r_mcnt == CW'(DATA_WIDTH - 1));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      w_next_state = r_state;
      w_we         = 1'b0;
      w_wdata      = '0;
      w_led_we     = 1'b0;
      w_branch     = 1'b0;
      w_ip_adv     = 1'b0;
      w_mul_start  = 1'b0;
      unique case (r_state)
         S_FETCH: w_next_state = S_EXEC;
         S_EXEC: begin
            w_next_state = S_FETCH;
            w_ip_adv     = 1'b1;
            case (w_op)
               OP_LED:  w_led_we = 1'b1;
               OP_BLE:  w_branch = (w_a <= w_b);
               OP_STO:  begin w_we = 1'b1; w_wdata = DATA_WIDTH'({w_src1, w_src0}); end
               OP_ADD:  begin w_we = 1'b1; w_wdata = w_a + w_b; end
               OP_JMP:  w_branch = 1'b1;
               OP_SUB:  begin w_we = 1'b1; w_wdata = w_a - w_b; end
               OP_MUL:  begin w_next_state = S_MUL; w_ip_adv = 1'b0; w_mul_start = 1'b1; end
               OP_HALT: begin w_next_state = S_HALT; w_ip_adv = 1'b0; end
               default: ;
            endcase
         end
         S_MUL: begin
            if (w_mul_last) begin
               w_next_state = S_FETCH;
               w_we         = 1'b1;
               w_wdata      = w_acc_next;
               w_ip_adv     = 1'b1;
            end
         end
         S_HALT: w_next_state = S_HALT;
         default: w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         r_state  <= S_FETCH;
         r_ir     <= '0;
         r_ip     <= '0;
         r_led    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_mcnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_FETCH) r_ir <= bus.iInstruction;
         if (w_ip_adv) r_ip <= w_branch ? IP_WIDTH'(w_dest) : r_ip + IP_WIDTH'(1);
         if (w_led_we) r_led <= w_a[LED_WIDTH-1:0];
         if (w_mul_start) begin
            r_mcand  <= w_a;
            r_mplier <= w_b;
            r_acc    <= '0;
            r_mcnt   <= '0;
         end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_mcnt   <= r_mcnt + CW'(1);
         end
      end
   end

   // NOTE: the register file has no reset; it keeps its contents across Reset and maps to plain RAM.
   always_ff @(posedge Clock) begin
      if (w_we) r_regs[w_dest] <= w_wdata;
   end

   assign bus.oIP     = r_ip;
   assign bus.oLed    = r_led;
   assign bus.oHalted = (r_state == S_HALT);
endmodule

// File: tb/tb_mini_alu_gen2.sv
// Self-checking bench for mini_alu_gen2: vector table, directed corner sequences,
// and random programs compared against an instruction-level reference model.
module tb_mini_alu_gen2;
   localparam int DW = 16, AW = 8, IPW = 16, LW = 8;
   localparam logic [27:0] HALT_INS = 28'h8000000;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   mini_alu_gen2_if #(.ADDR_WIDTH(AW), .IP_WIDTH(IPW), .LED_WIDTH(LW)) bus ();
   mini_alu_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IP_WIDTH(IPW), .LED_WIDTH(LW))
      dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   mini_alu_gen2_if #(.ADDR_WIDTH(AW), .IP_WIDTH(4), .LED_WIDTH(LW)) bus4 ();
   mini_alu_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IP_WIDTH(4), .LED_WIDTH(LW))
      dut4 (.Clock(Clock), .Reset(Reset), .bus(bus4));

   logic [27:0] prog [256];
   assign bus.iInstruction  = prog[bus.oIP[7:0]];
   assign bus4.iInstruction = '0;

   int n_vec = 0;
   int n_err = 0;

   int m_regs [256];
   int m_led, m_ip, m_cyc;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b, r3;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [27:0] enc(input int op, input int d, input int s1, input int s0);
      return {4'(op), 8'(d), 8'(s1), 8'(s0)};
   endfunction

   function automatic logic [27:0] sto(input int d, input int imm);
      return enc(3, d, (imm >> 8) & 255, imm & 255);
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = HALT_INS;
   endtask

   task automatic pulse_reset();
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      Reset = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clock);
      @(negedge Clock);
   endtask

   // Instruction-level model: executes the program array directly.
   task automatic model_run();
      int ip, op, d, s1, s0, a, b;
      ip = 0; m_led = 0; m_cyc = 0;
      for (int k = 0; k < 1000; k++) begin
         op = int'(prog[ip & 255][27:24]);
         d  = int'(prog[ip & 255][23:16]);
         s1 = int'(prog[ip & 255][15:8]);
         s0 = int'(prog[ip & 255][7:0]);
         a = m_regs[s1]; b = m_regs[s0];
         m_cyc += 2;
         if (op == 8) break;
         case (op)
            1: m_led = a & 255;
            3: m_regs[d] = (s1 << 8) | s0;
            4: m_regs[d] = (a + b) % 65536;
            6: m_regs[d] = (a - b + 65536) % 65536;
            7: begin m_regs[d] = int'((longint'(a) * longint'(b)) % 65536); m_cyc += DW; end
            default: ;
         endcase
         if (op == 5 || (op == 2 && a <= b)) ip = d;
         else ip = (ip + 1) % 65536;
      end
      m_ip = ip;
   endtask

   task automatic run_to_halt(input string name, output int cyc);
      cyc = 0;
      pulse_reset();
      while (bus.oHalted !== 1'b1 && cyc < 2000) begin
         step(1);
         cyc++;
      end
      if (bus.oHalted !== 1'b1) check({name, "_halt_timeout"}, 32'(cyc), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, bad;
      logic [15:0] ip_hold;
      logic [7:0]  led_hold;

      tbl[0] = '{4'd4, 16'd5,    16'd7,    16'h000C};
      tbl[1] = '{4'd4, 16'hFFFF, 16'h0002, 16'h0001};
      tbl[2] = '{4'd6, 16'd3,    16'd5,    16'hFFFE};
      tbl[3] = '{4'd6, 16'h1234, 16'h0234, 16'h1000};
      tbl[4] = '{4'd7, 16'd300,  16'd300,  16'h5F90};
      tbl[5] = '{4'd7, 16'hFFFF, 16'hFFFF, 16'h0001};
      tbl[6] = '{4'd7, 16'h0000, 16'h1234, 16'h0000};
      tbl[7] = '{4'd7, 16'h0100, 16'h0100, 16'h0000};

      clear_prog();
      @(negedge Clock);
      check("reset_ip", 32'(bus.oIP), 32'd0);
      check("reset_halted", 32'(bus.oHalted), 32'd0);

      for (int i = 0; i < 8; i++) begin
         clear_prog();
         prog[0] = sto(1, int'(tbl[i].a));
         prog[1] = sto(2, int'(tbl[i].b));
         prog[2] = enc(int'(tbl[i].op), 3, 1, 2);
         prog[3] = enc(1, 0, 3, 0);
         run_to_halt($sformatf("vec%0d", i), cyc);
         check($sformatf("vec%0d_r3", i), 32'(dut.r_regs[3]), 32'(tbl[i].r3));
         check($sformatf("vec%0d_led", i), 32'(bus.oLed), 32'(tbl[i].r3[7:0]));
         check($sformatf("vec%0d_ip", i), 32'(bus.oIP), 32'd4);
         check($sformatf("vec%0d_cycles", i), 32'(cyc), (tbl[i].op == 4'd7) ? 32'd26 : 32'd10);
      end

      // ADD program: LED result visible exactly after the eighth edge.
      clear_prog();
      prog[0] = sto(1, 5); prog[1] = sto(2, 7); prog[2] = enc(4, 3, 1, 2); prog[3] = enc(1, 0, 3, 0);
      pulse_reset();
      step(7);
      check("add_led_before", 32'(bus.oLed), 32'd0);
      step(1);
      check("add_led", 32'(bus.oLed), 32'h0C);
      check("add_ip", 32'(bus.oIP), 32'd4);

      // MUL timing: oIP holds during the multiply, write lands on the final MUL edge.
      clear_prog();
      prog[0] = sto(1, 300); prog[1] = sto(2, 300); prog[2] = enc(7, 3, 1, 2); prog[3] = enc(1, 0, 3, 0);
      prog[4] = sto(3, 0);
      pulse_reset();
      step(4);
      check("mul_ip_start", 32'(bus.oIP), 32'd2);
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         step(1);
         if (bus.oIP !== 16'd2 || bus.oLed !== 8'd0) bad++;
      end
      check("mul_ip_led_hold", 32'(bad), 32'd0);
      check("mul_r3_not_early", 32'(dut.r_regs[3] === 16'h5F90), 32'd0);
      step(1);
      check("mul_ip_done", 32'(bus.oIP), 32'd3);
      check("mul_r3", 32'(dut.r_regs[3]), 32'h5F90);
      step(2);
      check("mul_led", 32'(bus.oLed), 32'h90);

      // Branches: taken on equality, not taken when greater, unsigned compare, JMP.
      clear_prog();
      prog[0] = sto(1, 4); prog[1] = sto(2, 4); prog[2] = enc(2, 16'h10, 1, 2);
      run_to_halt("ble_eq", cyc);
      check("ble_eq_ip", 32'(bus.oIP), 32'h10);
      prog[0] = sto(1, 5);
      run_to_halt("ble_gt", cyc);
      check("ble_gt_ip", 32'(bus.oIP), 32'd3);
      prog[0] = sto(1, 16'h8000); prog[1] = sto(2, 1);
      run_to_halt("ble_uns", cyc);
      check("ble_unsigned_ip", 32'(bus.oIP), 32'd3);
      prog[3] = enc(5, 16'h20, 0, 0);
      run_to_halt("jmp", cyc);
      check("jmp_ip", 32'(bus.oIP), 32'h20);

      // HALT freezes oIP and oLed.
      clear_prog();
      prog[0] = sto(1, 16'h00A5); prog[1] = enc(1, 0, 1, 0); prog[2] = sto(1, 16'h0011);
      prog[3] = enc(15, 0, 0, 0);
      run_to_halt("halt", cyc);
      check("halt_ip", 32'(bus.oIP), 32'd4);
      ip_hold = bus.oIP; led_hold = bus.oLed;
      check("halt_led", 32'(led_hold), 32'hA5);
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (bus.oIP !== ip_hold || bus.oLed !== led_hold || bus.oHalted !== 1'b1) bad++;
      end
      check("halt_frozen", 32'(bad), 32'd0);

      // Asynchronous reset mid-MUL aborts with no write.
      clear_prog();
      prog[0] = sto(3, 16'hABCD); prog[1] = sto(1, 300); prog[2] = sto(2, 300);
      prog[3] = enc(1, 0, 3, 0); prog[4] = enc(7, 3, 1, 2);
      pulse_reset();
      step(15);
      check("abort_led_pre", 32'(bus.oLed), 32'hCD);
      #1 Reset = 1'b1;
      #1;
      check("abort_ip", 32'(bus.oIP), 32'd0);
      check("abort_led", 32'(bus.oLed), 32'd0);
      check("abort_halted", 32'(bus.oHalted), 32'd0);
      Reset = 1'b0;
      step(1);
      check("abort_r3", 32'(dut.r_regs[3]), 32'hABCD);
      check("abort_restart_ip", 32'(bus.oIP), 32'd0);

      // IP wrap on the 4-bit-IP instance running NOPs.
      pulse_reset();
      step(30);
      check("wrap_ip15", 32'(bus4.oIP), 32'd15);
      step(2);
      check("wrap_ip0", 32'(bus4.oIP), 32'd0);

      // Random straight-line programs with forward branches against the model.
      for (int t = 0; t < 25; t++) begin
         clear_prog();
         for (int r = 0; r < 4; r++) prog[r] = sto(r, int'($urandom_range(0, 65535)));
         for (int p = 4; p < 14; p++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if (op == 8) op = 4;
            if (op == 3) prog[p] = sto(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
            else if (op == 2 || op == 5)
               prog[p] = enc(op, int'($urandom_range(p + 1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
               prog[p] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end
         model_run();
         run_to_halt($sformatf("rnd%0d", t), cyc);
         for (int r = 0; r < 4; r++)
            check($sformatf("rnd%0d_r%0d", t, r), 32'(dut.r_regs[r]), 32'(m_regs[r]));
         check($sformatf("rnd%0d_led", t), 32'(bus.oLed), 32'(m_led));
         check($sformatf("rnd%0d_ip", t), 32'(bus.oIP), 32'(m_ip));
         check($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(m_cyc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
